// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// The FSM state encoding and the default operand width live here.
package serial_adder_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/serial_adder_full_adder.sv
// Purely combinational 1-bit full adder used by the serial adder datapath.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one bit pair per cycle, LSB first, through a single full adder.
// Optional signed-overflow output is enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy,
   output logic             done
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   state_t state_q, state_d;

   logic [WIDTH-1:0] aSh_q, aSh_d;
   logic [WIDTH-1:0] bSh_q, bSh_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic loadEn, shiftEn, finishEn, lastBit;
   logic faSum, faCout;

   assign lastBit = (count_q == CNT_W'(WIDTH - 1));

   full_adder u_fa (
      .a    (aSh_q[0]),
      .b    (bSh_q[0]),
      .cin  (carry_q),
      .sum  (faSum),
      .cout (faCout)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = SHIFT;
         SHIFT:   if (lastBit) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy     = (state_q != IDLE);
      loadEn   = (state_q == IDLE) && start;
      shiftEn  = (state_q == SHIFT);
      finishEn = (state_q == DONE);
   end

   // Operands shift right so bit 0 always feeds the adder; sum bits enter at the MSB.
   always_comb begin
      aSh_d    = aSh_q;
      bSh_d    = bSh_q;
      result_d = result_q;
      carry_d  = carry_q;
      count_d  = count_q;
      sum_d    = sum_q;
      cout_d   = cout_q;
      done_d   = 1'b0;
      if (loadEn) begin
         aSh_d   = a;
         bSh_d   = b;
         carry_d = cin;
         count_d = '0;
      end else if (shiftEn) begin
         aSh_d    = {1'b0, aSh_q[WIDTH-1:1]};
         bSh_d    = {1'b0, bSh_q[WIDTH-1:1]};
         result_d = {faSum, result_q[WIDTH-1:1]};
         carry_d  = faCout;
         count_d  = count_q + CNT_W'(1);
      end else if (finishEn) begin
         sum_d  = result_q;
         cout_d = carry_q;
         done_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         aSh_q    <= '0;
         bSh_q    <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
         count_q  <= '0;
         sum_q    <= '0;
         cout_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         aSh_q    <= aSh_d;
         bSh_q    <= bSh_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         count_q  <= count_d;
         sum_q    <= sum_d;
         cout_q   <= cout_d;
         done_q   <= done_d;
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;
   assign done = done_q;

`ifdef SERIAL_ADDER_OVF_EN
   logic msbCarry_q, msbCarry_d;
   logic ovf_q, ovf_d;

   // The carry into the MSB is the carry flop value while the last bit is being added.
   always_comb begin
      msbCarry_d = msbCarry_q;
      ovf_d      = ovf_q;
      if (shiftEn && lastBit) msbCarry_d = carry_q;
      if (finishEn)           ovf_d      = msbCarry_q ^ carry_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         msbCarry_q <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         msbCarry_q <= msbCarry_d;
         ovf_q      <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`endif

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal values 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an addition.
REQ-005 The block SHALL have ports a and b, inputs, WIDTH bits each: the operands.
REQ-006 The block SHALL have port cin, input, 1 bit: the carry-in.
REQ-007 The block SHALL have port sum, output, WIDTH bits: the result a+b+cin, modulo 2^WIDTH.
REQ-008 The block SHALL have port cout, output, 1 bit: the carry out of the MSB.
REQ-009 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: a one-cycle pulse when sum and cout are updated.

Function
REQ-011 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-012 In IDLE with start=1 at an edge, the block SHALL capture a, b and cin into internal shift registers and the carry flop, clear the bit counter and go to SHIFT.
REQ-013 In SHIFT, each cycle SHALL add one bit pair, LSB first, through a 1-bit full adder using the carry flop.
REQ-014 In SHIFT, each cycle SHALL shift the sum bit into the result register from the MSB end, update the carry flop and increment the counter.
REQ-015 After exactly WIDTH SHIFT cycles, the FSM SHALL go to DONE.
REQ-016 In DONE, the block SHALL load sum and cout from the result register and carry flop, assert done for exactly one cycle, and return to IDLE.
REQ-017 done SHALL be high in the cycle WIDTH+1 clocks after the edge that accepted start.
REQ-018 busy SHALL be high in SHIFT and DONE and low in IDLE.
REQ-019 start while busy=1 SHALL be ignored; operand changes after capture SHALL have no effect.
REQ-020 start held high continuously SHALL begin a new operation on the first IDLE edge, giving back-to-back results every WIDTH+2 cycles.
REQ-021 sum and cout SHALL hold their last values until the next DONE.
REQ-022 The counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap within an operation.

Reset
REQ-023 rst=1 at an edge SHALL force IDLE and clear sum, cout, busy, done, the counter, the carry flop and the shift registers to 0, including in the middle of SHIFT or DONE.
REQ-024 When rst and start are both high at the same edge, rst SHALL win and the start SHALL be discarded.
REQ-025 The first start SHALL be accepted at the first edge after rst deasserts.

Configuration
REQ-026 With macro SERIAL_ADDER_OVF_EN defined, the block SHALL have an output port ovf, 1 bit, reset 0.
REQ-027 ovf SHALL equal the carry into the MSB XOR cout (two's-complement signed overflow), updated together with sum in DONE.
REQ-028 Without SERIAL_ADDER_OVF_EN, the ovf port and its flop SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-029 Package serial_adder_pkg SHALL hold the FSM state enum (IDLE, SHIFT, DONE) and the default WIDTH constant.
REQ-030 Sub-module full_adder SHALL be purely combinational with ports a, b, cin, sum, cout, where sum = a^b^cin and cout = (a&b)|(cin&(a^b)).
REQ-031 serial_adder SHALL instantiate full_adder exactly once.

Verification (WIDTH=8)
REQ-032 a=0x0F, b=0x01, cin=0, start pulse -> busy high 9 cycles, done at start+9, sum=0x10, cout=0 (ovf=0).
REQ-033 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0.
REQ-034 a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1 (macro defined); with the macro undefined, sum and cout are identical.
REQ-035 a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-036 Start (0x01+0x01); 3 cycles later, start with a=0xAA, b=0x55 -> second start ignored, sum=0x02, and only one done pulse.
REQ-037 rst at SHIFT cycle 4 -> busy, done, sum and cout all 0 on the next cycle; then a fresh 0x10+0x20 -> sum=0x30, done at start+9.
